// File: rtl/bus_master_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_port_pkg
// Description : Shared widths, slave ids and FSM encoding for bus_master_port.
// Revision    : 1.0
// ============================================================================
package bus_master_port_pkg;

    localparam int ADDR_WIDTH    = 14;
    localparam int DATA_WIDTH    = 8;
    localparam int BURST_WIDTH   = 3;
    localparam int BIT_CNT_WIDTH = 4;

    // addr[13:12] selects the slave
    localparam logic [1:0] SLV1 = 2'd0;
    localparam logic [1:0] SLV2 = 2'd1;
    localparam logic [1:0] SLV3 = 2'd2;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_REQ      = 4'd1;
    localparam logic [3:0] ST_ADDR     = 4'd2;
    localparam logic [3:0] ST_WDATA    = 4'd3;
    localparam logic [3:0] ST_WAIT_ACK = 4'd4;
    localparam logic [3:0] ST_RWAIT    = 4'd5;
    localparam logic [3:0] ST_RDATA    = 4'd6;
    localparam logic [3:0] ST_NEXT     = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_REQ      = ST_REQ,
        S_ADDR     = ST_ADDR,
        S_WDATA    = ST_WDATA,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_RWAIT    = ST_RWAIT,
        S_RDATA    = ST_RDATA,
        S_NEXT     = ST_NEXT,
        S_DONE     = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_master_port_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_port_if
// Description : Shared serial bus between one master port, its arbiter and slaves.
// Revision    : 1.0
// ============================================================================
interface bus_master_port_if;

    logic bus_req;
    logic bus_grant;
    logic m_valid;
    logic m_rw;
    logic m_addr_out;
    logic m_data_out;
    logic m_data_in;
    logic slave_ready;

    modport master (
        output bus_req,
        output m_valid,
        output m_rw,
        output m_addr_out,
        output m_data_out,
        input  bus_grant,
        input  m_data_in,
        input  slave_ready
    );

    modport slave (
        input  bus_req,
        input  m_valid,
        input  m_rw,
        input  m_addr_out,
        input  m_data_out,
        output bus_grant,
        output m_data_in,
        output slave_ready
    );

endinterface
`default_nettype wire

// File: rtl/bus_master_port_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_shifter
// Description : Parallel-load / MSB-first shift register, used for TX and RX.
// Revision    : 1.0
// ============================================================================
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // load wins over shift so a new beat always starts from a clean word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (shift) begin
            r_q <= {r_q[WIDTH-2:0], shift_in};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_port
// Description : Master-side serial bus port: arbitrate, shift addr/data, collect ack/read data.
// Revision    : 1.0
// ============================================================================
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   read_en,
    input  logic [BURST_WIDTH-1:0] burst_mode,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    output logic                   request,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid,
    output logic                   error,
    bus_master_port_if.master      bus
);

    localparam int                       TO_WIDTH    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_WIDTH-1:0]      C_TO_LIMIT  = TO_WIDTH'(ACK_TIMEOUT);
    localparam logic [BIT_CNT_WIDTH-1:0] C_ADDR_LAST = BIT_CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] C_DATA_LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     r_rw;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [BURST_WIDTH-1:0]   r_beats_left;
    logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
    logic [TO_WIDTH-1:0]      r_to_cnt;
    logic                     r_error;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic                     r_data_valid;

    logic                     w_capture;
    logic                     w_next_beat;
    logic                     w_shift_addr;
    logic                     w_shift_data;
    logic                     w_rd_done;
    logic                     w_timeout;
    logic                     w_bit_inc;
    logic                     w_to_inc;
    logic                     w_load;
    logic                     w_valid;

    logic [ADDR_WIDTH-1:0]    w_addr_ld;
    logic [DATA_WIDTH-1:0]    w_data_ld;
    logic [ADDR_WIDTH-1:0]    w_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic                     w_addr_q_unused;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_next_beat  = 1'b0;
        w_shift_addr = 1'b0;
        w_shift_data = 1'b0;
        w_rd_done    = 1'b0;
        w_timeout    = 1'b0;
        w_bit_inc    = 1'b0;
        w_to_inc     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (bus.bus_grant) begin
                    w_state_nxt = S_ADDR;
                end
            end

            // losing the grant mid-beat restarts the beat via REQ, which reloads the shifters
            S_ADDR: begin
                if (!bus.bus_grant) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_shift_addr = 1'b1;
                    if (r_bit_cnt == C_ADDR_LAST) begin
                        w_state_nxt = r_rw ? S_RWAIT : S_WDATA;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end

            S_WDATA: begin
                if (!bus.bus_grant) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_shift_data = 1'b1;
                    if (r_bit_cnt == C_DATA_LAST) begin
                        w_state_nxt = S_WAIT_ACK;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end

            S_WAIT_ACK: begin
                if (bus.slave_ready) begin
                    w_state_nxt = S_NEXT;
                end else if (r_to_cnt == C_TO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            S_RWAIT: begin
                if (bus.slave_ready) begin
                    w_state_nxt = S_RDATA;
                end else if (r_to_cnt == C_TO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            S_RDATA: begin
                if (!bus.bus_grant) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_shift_data = 1'b1;
                    if (r_bit_cnt == C_DATA_LAST) begin
                        w_rd_done   = 1'b1;
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end

            S_NEXT: begin
                if (r_beats_left != '0) begin
                    w_next_beat = 1'b1;
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction context and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_beats_left <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_error      <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rw         <= read_en;
                r_addr       <= addr_in;
                r_data       <= data_in;
                r_beats_left <= burst_mode;
                r_error      <= 1'b0;
            end else if (w_next_beat) begin
                r_addr       <= w_addr_ld;
                r_data       <= w_data_ld;
                r_beats_left <= r_beats_left - BURST_WIDTH'(1);
            end

            if (w_timeout) begin
                r_error <= 1'b1;
            end

            r_bit_cnt <= w_bit_inc ? r_bit_cnt + BIT_CNT_WIDTH'(1) : '0;
            r_to_cnt  <= w_to_inc  ? r_to_cnt + TO_WIDTH'(1)       : '0;

            r_data_valid <= w_rd_done;
            if (w_rd_done) begin
                r_data_out <= {w_data_q[DATA_WIDTH-2:0], bus.m_data_in};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shifters: loaded in REQ (beat start or restart) and in NEXT (next beat)
    // ------------------------------------------------------------------------
    assign w_load    = (r_state == S_REQ) | w_next_beat;
    assign w_addr_ld = w_next_beat ? r_addr + ADDR_WIDTH'(1) : r_addr;
    assign w_data_ld = w_next_beat ? r_data + DATA_WIDTH'(1) : r_data;

    serial_shifter #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_shifter (
        .clk      (clk),
        .rst      (reset),
        .load     (w_load),
        .shift    (w_shift_addr),
        .shift_in (1'b0),
        .load_val (w_addr_ld),
        .q        (w_addr_q)
    );

    serial_shifter #(
        .WIDTH (DATA_WIDTH)
    ) u_data_shifter (
        .clk      (clk),
        .rst      (reset),
        .load     (w_load),
        .shift    (w_shift_data),
        .shift_in (bus.m_data_in),
        .load_val (w_data_ld),
        .q        (w_data_q)
    );

    assign w_addr_q_unused = &{1'b0, w_addr_q[ADDR_WIDTH-2:0]};

    // ------------------------------------------------------------------------
    // Outputs; m_valid is gated by the grant so a drop takes effect this cycle
    // ------------------------------------------------------------------------
    assign w_valid = ((r_state == S_ADDR) || (r_state == S_WDATA)) && bus.bus_grant;

    assign bus.m_valid    = w_valid;
    assign bus.m_rw       = w_valid & r_rw;
    assign bus.m_addr_out = w_valid && (r_state == S_ADDR)  && w_addr_q[ADDR_WIDTH-1];
    assign bus.m_data_out = w_valid && (r_state == S_WDATA) && w_data_q[DATA_WIDTH-1];
    assign bus.bus_req    = (r_state != S_IDLE) && (r_state != S_DONE);

    assign request    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign error      = r_error;

endmodule
`default_nettype wire
